// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the 6502 ALU operation sequencer.
// ALU_SEQ_DECIMAL_ADJUST_EN adds the DADJ state to the state encoding.
package alu_seq_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 4;

    // Flag bit positions within {N,V,Z,C}
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_C = 0;

    localparam logic [OP_W-1:0] OP_ADC = 4'h0;
    localparam logic [OP_W-1:0] OP_SBC = 4'h1;
    localparam logic [OP_W-1:0] OP_AND = 4'h2;
    localparam logic [OP_W-1:0] OP_ORA = 4'h3;
    localparam logic [OP_W-1:0] OP_EOR = 4'h4;
    localparam logic [OP_W-1:0] OP_LSR = 4'h5;
    localparam logic [OP_W-1:0] OP_ROR = 4'h6;
    localparam logic [OP_W-1:0] OP_ASL = 4'h7;
    localparam logic [OP_W-1:0] OP_ROL = 4'h8;
    localparam logic [OP_W-1:0] OP_CMP = 4'h9;
    localparam logic [OP_W-1:0] OP_INC = 4'hA;
    localparam logic [OP_W-1:0] OP_DEC = 4'hB;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_CAPT = 3'd2,
        ST_RESP = 3'd3
`ifdef ALU_SEQ_DECIMAL_ADJUST_EN
        ,
        ST_DADJ = 3'd4
`endif
    } state_t;

    // One cycle of ALU input-select / function-select drive
    typedef struct packed {
        logic              sb_add;
        logic              zero_add;
        logic              db_add;
        logic              db_n_add;
        logic              adl_add;
        logic              one_addc;
        logic              sums;
        logic              ands;
        logic              eors;
        logic              ors;
        logic              srs;
        logic [DATA_W-1:0] sb;
        logic [DATA_W-1:0] db;
    } alu_ctrl_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return op <= OP_DEC;
    endfunction

    // Ops whose carry comes from the ALU rather than the incoming C
    function automatic logic op_takes_acr(input logic [OP_W-1:0] op);
        return (op == OP_ADC) || (op == OP_SBC) || (op == OP_CMP) ||
               (op == OP_LSR) || (op == OP_ROR) || (op == OP_ASL) || (op == OP_ROL);
    endfunction

    function automatic logic op_takes_avr(input logic [OP_W-1:0] op);
        return (op == OP_ADC) || (op == OP_SBC);
    endfunction

    function automatic alu_ctrl_t alu_ctrl_decode(input logic [OP_W-1:0]   op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic              c);
        alu_ctrl_t ctl;
        ctl = '0;
        if (op_is_legal(op)) begin
            ctl.sb_add = 1'b1;
            ctl.sb     = a;
        end
        case (op)
            OP_ADC: begin ctl.db_add = 1'b1; ctl.db = b; ctl.one_addc = c; ctl.sums = 1'b1; end
            OP_SBC: begin ctl.db_n_add = 1'b1; ctl.db = b; ctl.one_addc = c; ctl.sums = 1'b1; end
            OP_AND: begin ctl.db_add = 1'b1; ctl.db = b; ctl.ands = 1'b1; end
            OP_ORA: begin ctl.db_add = 1'b1; ctl.db = b; ctl.ors = 1'b1; end
            OP_EOR: begin ctl.db_add = 1'b1; ctl.db = b; ctl.eors = 1'b1; end
            OP_LSR: begin ctl.srs = 1'b1; end
            OP_ROR: begin ctl.one_addc = c; ctl.srs = 1'b1; end
            OP_ASL: begin ctl.db_add = 1'b1; ctl.db = a; ctl.sums = 1'b1; end
            OP_ROL: begin ctl.db_add = 1'b1; ctl.db = a; ctl.one_addc = c; ctl.sums = 1'b1; end
            OP_CMP: begin ctl.db_n_add = 1'b1; ctl.db = b; ctl.one_addc = 1'b1; ctl.sums = 1'b1; end
            OP_INC: begin ctl.db_add = 1'b1; ctl.db = '0; ctl.one_addc = 1'b1; ctl.sums = 1'b1; end
            // DEC leaves DB unselected so the ALU sees its precharged FF
            OP_DEC: begin ctl.sums = 1'b1; end
            default: ;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_decimal_adjust.sv
// Combinational BCD correction of a binary ADC/SBC result (NMOS rules).
// Only present when ALU_SEQ_DECIMAL_ADJUST_EN is defined.
`ifdef ALU_SEQ_DECIMAL_ADJUST_EN
module decimal_adjust
    import alu_seq_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b_eff,
    input  logic              cin,
    input  logic [DATA_W-1:0] bin,
    input  logic              acr,
    input  logic              is_sub,
    output logic [DATA_W-1:0] result_c,
    output logic              carry_c
);

    logic [4:0]        lo_sum;
    logic              lo_fix;
    logic              hi_fix;
    logic [DATA_W-1:0] lo_adj;

    // Half-carry is rebuilt locally since the ALU does not export it
    always_comb begin
        lo_sum   = 5'(a[3:0]) + 5'(b_eff[3:0]) + 5'(cin);
        lo_fix   = 1'b0;
        hi_fix   = 1'b0;
        lo_adj   = bin;
        result_c = bin;
        carry_c  = acr;
        if (is_sub) begin
            lo_adj   = lo_sum[4] ? bin : bin - 8'h06;
            result_c = acr ? lo_adj : lo_adj - 8'h60;
        end else begin
            lo_fix   = lo_sum > 5'd9;
            lo_adj   = lo_fix ? bin + 8'h06 : bin;
            hi_fix   = (lo_adj[7:4] > 4'd9) || acr;
            result_c = hi_fix ? lo_adj + 8'h60 : lo_adj;
            carry_c  = hi_fix;
        end
    end

endmodule
`endif

// File: rtl/alu_op_sequencer.sv
// Sequences one 6502 ALU operation per request: drive controls, capture, respond.
// Define ALU_SEQ_DECIMAL_ADJUST_EN to add BCD correction for ADC/SBC with D set.
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_c,
    input  logic              i_v,
    input  logic              i_d,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_result,
    output logic              o_result_we,
    output logic [FLAG_W-1:0] o_flags,
    output logic              o_illegal,
    output logic [DATA_W-1:0] o_sb,
    output logic [DATA_W-1:0] o_db,
    output logic              o_sb_add,
    output logic              o_0_add,
    output logic              o_db_add,
    output logic              o_db_n_add,
    output logic              o_adl_add,
    output logic              o_1_addc,
    output logic              o_sums,
    output logic              o_ands,
    output logic              o_eors,
    output logic              o_ors,
    output logic              o_srs,
    input  logic [DATA_W-1:0] i_add,
    input  logic              i_acr,
    input  logic              i_avr
);

    state_t            state_q, state_nxt;
    alu_ctrl_t         ctrl_q, ctrl_nxt;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              c_q, v_q;
    logic              accept;
    logic              req_ready_nxt, rsp_valid_nxt, we_nxt, illegal_nxt;
    logic [DATA_W-1:0] result_nxt;
    logic [FLAG_W-1:0] flags_nxt;

`ifdef ALU_SEQ_DECIMAL_ADJUST_EN
    logic              d_q, acr_q;
    logic [DATA_W-1:0] dec_result_c;
    logic              dec_carry_c;

    decimal_adjust u_decimal_adjust (
        .a        (a_q),
        .b_eff    ((op_q == OP_SBC) ? ~b_q : b_q),
        .cin      (c_q),
        .bin      (o_result),
        .acr      (acr_q),
        .is_sub   (op_q == OP_SBC),
        .result_c (dec_result_c),
        .carry_c  (dec_carry_c)
    );
`else
    logic unused_d;
    assign unused_d = i_d;
`endif

    assign accept = (state_q == ST_IDLE) && i_req_valid;

    // Next state and next values of every registered output
    always_comb begin
        state_nxt   = state_q;
        ctrl_nxt    = '0;
        result_nxt  = o_result;
        flags_nxt   = o_flags;
        we_nxt      = o_result_we;
        illegal_nxt = o_illegal;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_EXEC;
                    ctrl_nxt  = alu_ctrl_decode(i_op, i_a, i_b, i_c);
                end
            end
            ST_EXEC: state_nxt = ST_CAPT;
            ST_CAPT: begin
                state_nxt = ST_RESP;
                if (op_is_legal(op_q)) begin
                    result_nxt        = i_add;
                    flags_nxt[FLAG_N] = i_add[DATA_W-1];
                    flags_nxt[FLAG_Z] = (i_add == '0);
                    flags_nxt[FLAG_C] = op_takes_acr(op_q) ? i_acr : c_q;
                    flags_nxt[FLAG_V] = op_takes_avr(op_q) ? i_avr : v_q;
                    we_nxt            = (op_q != OP_CMP);
                    illegal_nxt       = 1'b0;
                end else begin
                    result_nxt        = a_q;
                    flags_nxt[FLAG_N] = a_q[DATA_W-1];
                    flags_nxt[FLAG_Z] = (a_q == '0);
                    flags_nxt[FLAG_C] = c_q;
                    flags_nxt[FLAG_V] = v_q;
                    we_nxt            = 1'b0;
                    illegal_nxt       = 1'b1;
                end
`ifdef ALU_SEQ_DECIMAL_ADJUST_EN
                if (d_q && op_takes_avr(op_q)) begin
                    state_nxt = ST_DADJ;
                end
`endif
            end
`ifdef ALU_SEQ_DECIMAL_ADJUST_EN
            // N/V/Z stay as computed from the binary sum
            ST_DADJ: begin
                state_nxt         = ST_RESP;
                result_nxt        = dec_result_c;
                flags_nxt[FLAG_C] = dec_carry_c;
            end
`endif
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        req_ready_nxt = (state_nxt == ST_IDLE);
        rsp_valid_nxt = (state_nxt == ST_RESP);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            ctrl_q      <= '0;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_result    <= '0;
            o_flags     <= '0;
            o_result_we <= 1'b0;
            o_illegal   <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            ctrl_q      <= ctrl_nxt;
            o_req_ready <= req_ready_nxt;
            o_rsp_valid <= rsp_valid_nxt;
            o_result    <= result_nxt;
            o_flags     <= flags_nxt;
            o_result_we <= we_nxt;
            o_illegal   <= illegal_nxt;
            if (accept) begin
                op_q <= i_op;
                a_q  <= i_a;
                b_q  <= i_b;
                c_q  <= i_c;
                v_q  <= i_v;
            end
        end
    end

`ifdef ALU_SEQ_DECIMAL_ADJUST_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            d_q   <= 1'b0;
            acr_q <= 1'b0;
        end else begin
            if (accept) begin
                d_q <= i_d;
            end
            if (state_q == ST_CAPT) begin
                acr_q <= i_acr;
            end
        end
    end
`endif

    assign o_sb       = ctrl_q.sb;
    assign o_db       = ctrl_q.db;
    assign o_sb_add   = ctrl_q.sb_add;
    assign o_0_add    = ctrl_q.zero_add;
    assign o_db_add   = ctrl_q.db_add;
    assign o_db_n_add = ctrl_q.db_n_add;
    assign o_adl_add  = ctrl_q.adl_add;
    assign o_1_addc   = ctrl_q.one_addc;
    assign o_sums     = ctrl_q.sums;
    assign o_ands     = ctrl_q.ands;
    assign o_eors     = ctrl_q.eors;
    assign o_ors      = ctrl_q.ors;
    assign o_srs      = ctrl_q.srs;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU and 6502 result model.
module tb_alu_op_sequencer;

    logic       i_clk = 1'b0;
    logic       i_reset_n;
    logic       i_req_valid, o_req_ready;
    logic [3:0] i_op;
    logic [7:0] i_a, i_b;
    logic       i_c, i_v, i_d;
    logic       o_rsp_valid, i_rsp_ready;
    logic [7:0] o_result;
    logic       o_result_we;
    logic [3:0] o_flags;
    logic       o_illegal;
    logic [7:0] o_sb, o_db;
    logic       o_sb_add, o_0_add, o_db_add, o_db_n_add, o_adl_add;
    logic       o_1_addc, o_sums, o_ands, o_eors, o_ors, o_srs;
    logic [7:0] alu_add;
    logic       alu_acr, alu_avr;

    alu_op_sequencer dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_v(i_v), .i_d(i_d),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_result(o_result), .o_result_we(o_result_we), .o_flags(o_flags),
        .o_illegal(o_illegal), .o_sb(o_sb), .o_db(o_db),
        .o_sb_add(o_sb_add), .o_0_add(o_0_add), .o_db_add(o_db_add),
        .o_db_n_add(o_db_n_add), .o_adl_add(o_adl_add), .o_1_addc(o_1_addc),
        .o_sums(o_sums), .o_ands(o_ands), .o_eors(o_eors), .o_ors(o_ors), .o_srs(o_srs),
        .i_add(alu_add), .i_acr(alu_acr), .i_avr(alu_avr)
    );

    always #5 i_clk = ~i_clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned cyc    = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ALU behaviour: latches the selected function at each rising edge
    function automatic logic [9:0] alu_fn(input logic sba, input logic [7:0] sb, input logic dba,
                                          input logic dbn, input logic [7:0] db, input logic cin,
                                          input logic sm, input logic an, input logic eo,
                                          input logic orr, input logic sr);
        logic [7:0] ai, bi;
        logic [8:0] s;
        ai = sba ? sb : 8'h00;
        bi = dba ? db : (dbn ? ~db : 8'hFF);
        s  = {1'b0, ai} + {1'b0, bi} + {8'h00, cin};
        if (sm)       return {(ai[7] == bi[7]) && (s[7] != ai[7]), s[8], s[7:0]};
        else if (an)  return {2'b00, ai & bi};
        else if (eo)  return {2'b00, ai ^ bi};
        else if (orr) return {2'b00, ai | bi};
        else if (sr)  return {1'b0, ai[0], cin, ai[7:1]};
        return 10'h000;
    endfunction

    always @(posedge i_clk)
        {alu_avr, alu_acr, alu_add} <= alu_fn(o_sb_add, o_sb, o_db_add, o_db_n_add, o_db, o_1_addc,
                                              o_sums, o_ands, o_eors, o_orr_w(), o_srs);

    function automatic logic o_orr_w();
        return o_ors;
    endfunction

    // Expected control lines while the op is being executed
    function automatic logic [26:0] ctrl_model(input logic [3:0] op, input logic [7:0] a,
                                               input logic [7:0] b, input logic c);
        logic sba, dba, dbn, cin, sm, an, eo, orr, sr;
        logic [7:0] sb, db;
        {sba, dba, dbn, cin, sm, an, eo, orr, sr} = 9'b0;
        sb = 8'h00;
        db = 8'h00;
        if (op <= 4'hB) begin sba = 1'b1; sb = a; end
        case (op)
            4'h0: {dba, db, cin, sm} = {1'b1, b, c, 1'b1};
            4'h1: {dbn, db, cin, sm} = {1'b1, b, c, 1'b1};
            4'h2: {dba, db, an}      = {1'b1, b, 1'b1};
            4'h3: {dba, db, orr}     = {1'b1, b, 1'b1};
            4'h4: {dba, db, eo}      = {1'b1, b, 1'b1};
            4'h5: sr = 1'b1;
            4'h6: {cin, sr}          = {c, 1'b1};
            4'h7: {dba, db, sm}      = {1'b1, a, 1'b1};
            4'h8: {dba, db, cin, sm} = {1'b1, a, c, 1'b1};
            4'h9: {dbn, db, cin, sm} = {1'b1, b, 1'b1, 1'b1};
            4'hA: {dba, db, cin, sm} = {1'b1, 8'h00, 1'b1, 1'b1};
            4'hB: sm = 1'b1;
            default: ;
        endcase
        return {sba, 1'b0, dba, dbn, 1'b0, cin, sm, an, eo, orr, sr, sb, db};
    endfunction

    // 6502 semantics: {illegal, we, N, V, Z, C, result}
    function automatic logic [13:0] resp_model(input logic [3:0] op, input logic [7:0] a,
                                               input logic [7:0] b, input logic c,
                                               input logic v, input logic d);
        logic [8:0] s;
        logic [7:0] r, bin;
        logic cf, vf;
        logic [4:0] lo;
        cf = c; vf = v; r = 8'h00; s = 9'h000;
        case (op)
            4'h0: begin s = {1'b0, a} + {1'b0, b} + {8'h00, c}; r = s[7:0]; cf = s[8];
                        vf = (a[7] == b[7]) && (r[7] != a[7]); end
            4'h1: begin s = {1'b0, a} + {1'b0, ~b} + {8'h00, c}; r = s[7:0]; cf = s[8];
                        vf = (a[7] != b[7]) && (r[7] != a[7]); end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: begin r = a >> 1; cf = a[0]; end
            4'h6: begin r = {c, a[7:1]}; cf = a[0]; end
            4'h7: begin r = {a[6:0], 1'b0}; cf = a[7]; end
            4'h8: begin r = {a[6:0], c}; cf = a[7]; end
            4'h9: begin s = {1'b0, a} + {1'b0, ~b} + 9'h001; r = s[7:0]; cf = s[8]; end
            4'hA: r = a + 8'h01;
            4'hB: r = a - 8'h01;
            default: return {1'b1, 1'b0, a[7], v, a == 8'h00, c, a};
        endcase
        bin = r;
`ifdef ALU_SEQ_DECIMAL_ADJUST_EN
        if (d && op == 4'h0) begin
            lo = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'h0, c};
            if (lo > 5'd9) r = r + 8'h06;
            if (r[7:4] > 4'd9 || cf) begin r = r + 8'h60; cf = 1'b1; end
        end else if (d && op == 4'h1) begin
            lo = {1'b0, a[3:0]} + {1'b0, ~b[3:0]} + {4'h0, c};
            if (lo < 5'd16) r = r - 8'h06;
            if (!cf) r = r - 8'h60;
        end
`else
        lo = {4'h0, d};
`endif
        return {1'b0, op != 4'h9, bin[7], vf, bin == 8'h00, cf, r};
    endfunction

    // Scoreboard state for the op in flight
    bit          chk_en = 1'b0;
    bit          busy   = 1'b0;
    int unsigned acc_cyc;
    int          lat, k_cmp;
    logic [26:0] exp_ctrl;
    logic [13:0] exp_rsp;
    logic [26:0] ctrl_vec;
    assign ctrl_vec = {o_sb_add, o_0_add, o_db_add, o_db_n_add, o_adl_add, o_1_addc,
                       o_sums, o_ands, o_eors, o_ors, o_srs, o_sb, o_db};

    // Every cycle: handshake, control lines and response against the model
    always @(negedge i_clk) begin
        if (chk_en && i_reset_n) begin
            if (!busy) begin
                check("idle_req_ready", 32'(o_req_ready), 32'd1);
                check("idle_rsp_valid", 32'(o_rsp_valid), 32'd0);
                check("idle_ctrl", 32'(ctrl_vec), 32'd0);
            end else begin
                k_cmp = int'(cyc - acc_cyc) + 1;
                check("busy_req_ready", 32'(o_req_ready), 32'd0);
                check("rsp_valid_timing", 32'(o_rsp_valid), 32'(k_cmp >= lat));
                check("exec_ctrl", 32'(ctrl_vec), (k_cmp == 1) ? 32'(exp_ctrl) : 32'd0);
                if (k_cmp >= lat) begin
                    check("rsp_result", 32'(o_result), 32'(exp_rsp[7:0]));
                    check("rsp_flags", 32'(o_flags), 32'(exp_rsp[11:8]));
                    check("rsp_we", 32'(o_result_we), 32'(exp_rsp[12]));
                    check("rsp_illegal", 32'(o_illegal), 32'(exp_rsp[13]));
                end
            end
        end
    end

    task automatic run_op(input string name, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic c, input logic v, input logic d,
                          input int hold, input logic [7:0] lit_res, input logic [3:0] lit_flags,
                          input logic lit_we, input logic lit_ill);
        int n;
        @(negedge i_clk);
        i_op = op; i_a = a; i_b = b; i_c = c; i_v = v; i_d = d;
        i_req_valid = 1'b1;
        exp_ctrl = ctrl_model(op, a, b, c);
        exp_rsp  = resp_model(op, a, b, c, v, d);
        lat = 3;
`ifdef ALU_SEQ_DECIMAL_ADJUST_EN
        if (d && op <= 4'h1) lat = 4;
`endif
        @(posedge i_clk);
        #1;
        busy = 1'b1;
        acc_cyc = cyc;
        i_req_valid = 1'b0;
        i_op = 4'($urandom); i_a = 8'($urandom); i_b = 8'($urandom);
        i_c = 1'($urandom); i_v = 1'($urandom); i_d = 1'($urandom);
        n = 0;
        while (o_rsp_valid !== 1'b1 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 20) check({name, "_rsp_timeout"}, 32'(o_rsp_valid), 32'd1);
        repeat (hold) @(negedge i_clk);
        check({name, "_result"}, 32'(o_result), 32'(lit_res));
        check({name, "_flags"}, 32'(o_flags), 32'(lit_flags));
        check({name, "_we"}, 32'(o_result_we), 32'(lit_we));
        check({name, "_illegal"}, 32'(o_illegal), 32'(lit_ill));
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        #1;
        busy = 1'b0;
        i_rsp_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_req_ready"}, 32'(o_req_ready), 32'd1);
        check({name, "_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
        check({name, "_result"}, 32'(o_result), 32'd0);
        check({name, "_flags"}, 32'(o_flags), 32'd0);
        check({name, "_we"}, 32'(o_result_we), 32'd0);
        check({name, "_illegal"}, 32'(o_illegal), 32'd0);
        check({name, "_ctrl"}, 32'(ctrl_vec), 32'd0);
    endtask

    initial begin
        i_reset_n = 1'b0; i_req_valid = 1'b0; i_rsp_ready = 1'b0;
        i_op = 4'h0; i_a = 8'h00; i_b = 8'h00; i_c = 1'b0; i_v = 1'b0; i_d = 1'b0;
        repeat (3) @(negedge i_clk);
        check_reset_values("reset");
        i_reset_n = 1'b1;
        chk_en = 1'b1;

        //      name    op    a      b      c     v     d    hold lit_res  N V Z C    we    ill
        run_op("adc",  4'h0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0, 0, 8'hA0, 4'b1100, 1'b1, 1'b0);
        run_op("sbc",  4'h1, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 0, 8'hFF, 4'b1000, 1'b1, 1'b0);
        run_op("cmp",  4'h9, 8'h40, 8'h40, 1'b0, 1'b1, 1'b0, 0, 8'h00, 4'b0111, 1'b0, 1'b0);
        run_op("ror",  4'h6, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h80, 4'b1001, 1'b1, 1'b0);
        run_op("lsr",  4'h5, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00, 4'b0011, 1'b1, 1'b0);
        run_op("dec",  4'hB, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'hFF, 4'b1001, 1'b1, 1'b0);
        run_op("inc",  4'hA, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00, 4'b0010, 1'b1, 1'b0);
        run_op("asl",  4'h7, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h02, 4'b0001, 1'b1, 1'b0);
        run_op("rol",  4'h8, 8'h81, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h03, 4'b0001, 1'b1, 1'b0);
        run_op("and",  4'h2, 8'hF0, 8'h3C, 1'b1, 1'b1, 1'b0, 0, 8'h30, 4'b0101, 1'b1, 1'b0);
        run_op("ora",  4'h3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00, 4'b0010, 1'b1, 1'b0);
        run_op("eor",  4'h4, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0, 0, 8'hF0, 4'b1000, 1'b1, 1'b0);
        run_op("hold", 4'h0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0, 5, 8'hA0, 4'b1100, 1'b1, 1'b0);
        run_op("ill_c", 4'hC, 8'h00, 8'h12, 1'b0, 1'b1, 1'b0, 0, 8'h00, 4'b0110, 1'b0, 1'b1);
`ifdef ALU_SEQ_DECIMAL_ADJUST_EN
        run_op("dadc", 4'h0, 8'h19, 8'h28, 1'b0, 1'b0, 1'b1, 0, 8'h47, 4'b0000, 1'b1, 1'b0);
        run_op("dadc_c", 4'h0, 8'h58, 8'h46, 1'b1, 1'b0, 1'b1, 0, 8'h05, 4'b1101, 1'b1, 1'b0);
        run_op("dsbc", 4'h1, 8'h50, 8'h01, 1'b1, 1'b0, 1'b1, 0, 8'h49, 4'b0001, 1'b1, 1'b0);
`else
        run_op("dadc", 4'h0, 8'h19, 8'h28, 1'b0, 1'b0, 1'b1, 0, 8'h41, 4'b0000, 1'b1, 1'b0);
        run_op("dadc_c", 4'h0, 8'h58, 8'h46, 1'b1, 1'b0, 1'b1, 0, 8'h9F, 4'b1100, 1'b1, 1'b0);
        run_op("dsbc", 4'h1, 8'h50, 8'h01, 1'b1, 1'b0, 1'b1, 0, 8'h4F, 4'b0001, 1'b1, 1'b0);
`endif

        // Abort an op with reset while its controls are on the bus
        @(negedge i_clk);
        i_op = 4'h0; i_a = 8'h12; i_b = 8'h34; i_c = 1'b1; i_v = 1'b0; i_d = 1'b0;
        i_req_valid = 1'b1;
        exp_ctrl = ctrl_model(4'h0, 8'h12, 8'h34, 1'b1);
        @(posedge i_clk);
        #2;
        i_req_valid = 1'b0;
        check("abort_exec_ctrl", 32'(ctrl_vec), 32'(exp_ctrl));
        i_reset_n = 1'b0;
        #1;
        check_reset_values("abort");
        @(negedge i_clk);
        #2;
        i_reset_n = 1'b1;

        run_op("ill_e", 4'hE, 8'h85, 8'h77, 1'b1, 1'b0, 1'b0, 0, 8'h85, 4'b1001, 1'b0, 1'b1);
        repeat (2) @(negedge i_clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
